// File: rtl/grayscale_pack_pkg.sv
// Shared constants and types for the RGB565-to-grayscale packing stream.
// Optional feature macro: GRAYSCALE_PACK_OVF_COUNT_EN (see grayscale_pack_stream).
package grayscale_pack_pkg;

  // Luminance coefficients; they sum to 256 so (sum >> 8) never exceeds 255.
  localparam int COEF_R = 54;
  localparam int COEF_G = 183;
  localparam int COEF_B = 19;

  localparam int PIXEL_W        = 16;
  localparam int GRAY_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  // One FIFO entry: line-end marker plus four packed gray bytes.
  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

  // Byte lane that the next gray byte will be written into.
  typedef enum logic [1:0] {
    BYTE0 = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2,
    BYTE3 = 2'd3
  } pack_state_t;

  // Widen a 5-bit channel to 8 bits by replicating its top bits.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  // Widen a 6-bit channel to 8 bits by replicating its top bits.
  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/grayscale_pack_fifo.sv
// Synchronous FIFO of packed gray words. The head entry is read straight from
// registered storage, so nothing on the read side depends on pop combinationally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module grayscale_pack_fifo
  import grayscale_pack_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  fifo_entry_t         push_entry,
  input  logic                pop,
  output fifo_entry_t         head,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE = 1;
  localparam logic [DEPTH_LOG2:0] LEVEL_MAX = DEPTH;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  fifo_entry_t           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == LEVEL_MAX);
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage write. NOTE: the array is deliberately left out of reset; the
  // pointers and count define which entries are meaningful.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LEVEL_ONE;
        2'b01:   count <= count - LEVEL_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/grayscale_pack_stream.sv
// RGB565 pixels -> 8-bit luminance -> four bytes per 32-bit word -> FIFO.
// Two register stages compute the gray byte; the packer fills byte lanes and
// pushes on lane 3 or at end of line. The camera cannot be stalled, so a word
// that meets a full FIFO is dropped and the sticky overflow flag is raised.
// Define GRAYSCALE_PACK_OVF_COUNT_EN to add a saturating 16-bit drop counter.
module grayscale_pack_stream
  import grayscale_pack_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     s_pixel_valid,
  input  logic [PIXEL_W-1:0]       s_pixel_data,
  input  logic                     s_end_of_line,
  output logic                     m_word_valid,
  output logic [WORD_W-1:0]        m_word_data,
  output logic                     m_word_last,
  input  logic                     m_word_ready,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level,
`ifdef GRAYSCALE_PACK_OVF_COUNT_EN
  output logic [15:0]              overflow_count,
`endif
  output logic                     overflow
);

  // Stage 1: weighted channel products.
  logic        s1_valid;
  logic        s1_eol;
  logic [15:0] s1_prod_r;
  logic [15:0] s1_prod_g;
  logic [15:0] s1_prod_b;

  // Stage 2: gray byte.
  logic              s2_valid;
  logic              s2_eol;
  logic [GRAY_W-1:0] s2_gray;

  // Packer.
  pack_state_t       state;
  pack_state_t       state_next;
  logic [WORD_W-1:0] pack_reg;
  logic [WORD_W-1:0] pack_next;
  logic [WORD_W-1:0] lane_word;
  logic              push;
  fifo_entry_t       push_entry;

  // FIFO side.
  fifo_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        drop;
  logic [15:0] lum_sum;

  assign lum_sum = s1_prod_r + s1_prod_g + s1_prod_b;

  // Pipeline valid/EOL flags; only these need reset to flush the pipe.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_eol   <= 1'b0;
      s2_valid <= 1'b0;
      s2_eol   <= 1'b0;
    end else begin
      s1_valid <= s_pixel_valid;
      s1_eol   <= s_pixel_valid && s_end_of_line;
      s2_valid <= s1_valid;
      s2_eol   <= s1_valid && s1_eol;
    end
  end

  // Pipeline datapath; qualified by the valid flags, so no reset needed.
  always_ff @(posedge clock) begin
    s1_prod_r <= 16'(COEF_R) * 16'(expand5(s_pixel_data[15:11]));
    s1_prod_g <= 16'(COEF_G) * 16'(expand6(s_pixel_data[10:5]));
    s1_prod_b <= 16'(COEF_B) * 16'(expand5(s_pixel_data[4:0]));
    s2_gray   <= lum_sum[15:8];
  end

  // Packer next-state: merge the new byte into its lane, push on lane 3 or EOL.
  always_comb begin
    state_next = state;
    pack_next  = pack_reg;
    lane_word  = pack_reg;
    push       = 1'b0;
    push_entry = '0;
    if (s2_valid) begin
      lane_word[{state, 3'b000} +: GRAY_W] = s2_gray;
      if (state == BYTE3 || s2_eol) begin
        // Clearing the pack register keeps upper lanes zero for partial words.
        push            = 1'b1;
        push_entry.data = lane_word;
        push_entry.last = s2_eol;
        pack_next       = '0;
        state_next      = BYTE0;
      end else begin
        pack_next = lane_word;
        case (state)
          BYTE0:   state_next = BYTE1;
          BYTE1:   state_next = BYTE2;
          default: state_next = BYTE3;
        endcase
      end
    end
  end

  // Packer state and partial-word register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= BYTE0;
      pack_reg <= '0;
    end else begin
      state    <= state_next;
      pack_reg <= pack_next;
    end
  end

  assign pop  = m_word_valid && m_word_ready;
  assign drop = push && fifo_full && !pop;

  grayscale_pack_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  assign m_word_valid = !fifo_empty;
  assign m_word_data  = fifo_empty ? '0 : head.data;
  assign m_word_last  = fifo_empty ? 1'b0 : head.last;

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef GRAYSCALE_PACK_OVF_COUNT_EN
  // Saturating count of dropped words.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_count <= '0;
    end else if (drop && overflow_count != 16'hFFFF) begin
      overflow_count <= overflow_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_grayscale_pack_stream.sv
// Directed, table-driven bench for grayscale_pack_stream with hand-computed
// gray values, plus sequences for EOL, overflow, full push/pop and reset.
module tb_grayscale_pack_stream;

  logic        clock = 1'b0;
  logic        reset;
  logic        s_pixel_valid;
  logic [15:0] s_pixel_data;
  logic        s_end_of_line;
  logic        m_word_valid;
  logic [31:0] m_word_data;
  logic        m_word_last;
  logic        m_word_ready;
  logic [3:0]  fifo_level;
  logic        overflow;
`ifdef GRAYSCALE_PACK_OVF_COUNT_EN
  logic [15:0] overflow_count;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  grayscale_pack_stream #(.FIFO_DEPTH_LOG2(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .s_pixel_valid  (s_pixel_valid),
    .s_pixel_data   (s_pixel_data),
    .s_end_of_line  (s_end_of_line),
    .m_word_valid   (m_word_valid),
    .m_word_data    (m_word_data),
    .m_word_last    (m_word_last),
    .m_word_ready   (m_word_ready),
    .fifo_level     (fifo_level),
`ifdef GRAYSCALE_PACK_OVF_COUNT_EN
    .overflow_count (overflow_count),
`endif
    .overflow       (overflow)
  );

  typedef struct {
    string            name;
    logic [3:0][15:0] pix;   // pix[0] is sent first
    logic [31:0]      word;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_pixel(input logic [15:0] data, input logic eol);
    s_pixel_valid = 1'b1;
    s_pixel_data  = data;
    s_end_of_line = eol;
    tick();
    s_pixel_valid = 1'b0;
    s_end_of_line = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for a word, compare it, then advance one edge so it pops
  // when m_word_ready is high.
  task automatic expect_word(input string name, input logic [31:0] data, input logic last);
    int n = 0;
    while (!m_word_valid && n < 20) begin
      tick();
      n++;
    end
    check({name, "_valid"}, 64'(m_word_valid), 64'd1);
    check({name, "_data"},  64'(m_word_data),  64'(data));
    check({name, "_last"},  64'(m_word_last),  64'(last));
    tick();
  endtask

  logic [15:0] ovf_pix [9];
  logic [7:0]  ovf_gray [8];

  initial begin
    vecs[0] = '{"mix_a",  {16'h07E0, 16'hF800, 16'h0000, 16'hFFFF}, 32'hB63500FF};
    vecs[1] = '{"blue",   {16'h001F, 16'h001F, 16'h001F, 16'h001F}, 32'h12121212};
    vecs[2] = '{"white",  {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 32'hFFFFFFFF};
    vecs[3] = '{"black",  {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 32'h00000000};
    vecs[4] = '{"mix_b",  {16'hFFFF, 16'h001F, 16'h07E0, 16'hF800}, 32'hFF12B635};
    vecs[5] = '{"mid",    {16'h8410, 16'h0000, 16'h0000, 16'h8410}, 32'h82000082};

    ovf_pix  = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 16'h8410, 16'hFFE0, 16'hF81F, 16'h07FF, 16'h0000};
    ovf_gray = '{8'hFF, 8'h35, 8'hB6, 8'h12, 8'h82, 8'hEC, 8'h48, 8'hC9};

    s_pixel_valid = 1'b0;
    s_pixel_data  = '0;
    s_end_of_line = 1'b0;
    m_word_ready  = 1'b1;

    // Reset state.
    do_reset();
    check("rst_valid", 64'(m_word_valid), 64'd0);
    check("rst_level", 64'(fifo_level),   64'd0);
    check("rst_ovf",   64'(overflow),     64'd0);
    check("rst_data",  64'(m_word_data),  64'd0);
    check("rst_last",  64'(m_word_last),  64'd0);

    // Latency: word appears three cycles after the 4th pixel is sampled.
    send_pixel(16'hFFFF, 1'b0);
    send_pixel(16'h0000, 1'b0);
    send_pixel(16'hF800, 1'b0);
    send_pixel(16'h07E0, 1'b0);
    check("lat_n1_valid", 64'(m_word_valid), 64'd0);
    tick();
    check("lat_n2_valid", 64'(m_word_valid), 64'd0);
    tick();
    check("lat_n3_valid", 64'(m_word_valid), 64'd1);
    check("lat_n3_data",  64'(m_word_data),  64'hB63500FF);
    check("lat_n3_last",  64'(m_word_last),  64'd0);
    tick();
    check("lat_popped", 64'(m_word_valid), 64'd0);

    // Table of full words.
    for (int v = 0; v < 6; v++) begin
      for (int p = 0; p < 4; p++) send_pixel(vecs[v].pix[p], 1'b0);
      expect_word(vecs[v].name, vecs[v].word, 1'b0);
    end

    // Partial word on EOL.
    for (int p = 0; p < 6; p++) send_pixel(16'h001F, p == 5);
    expect_word("eol_w0", 32'h12121212, 1'b0);
    expect_word("eol_w1", 32'h00001212, 1'b1);

    // EOL on lane 3: full word marked last.
    for (int p = 0; p < 4; p++) send_pixel(16'hF800, p == 3);
    expect_word("eol_lane3", 32'h35353535, 1'b1);

    // Overflow: fill eight words, then a ninth is dropped.
    m_word_ready = 1'b0;
    for (int w = 0; w < 8; w++) begin
      send_pixel(ovf_pix[w], 1'b0);
      for (int p = 1; p < 4; p++) send_pixel(16'h0000, 1'b0);
    end
    tick(); tick(); tick();
    check("ovf_full_level", 64'(fifo_level), 64'd8);
    check("ovf_before",     64'(overflow),   64'd0);
    send_pixel(ovf_pix[8], 1'b0);
    for (int p = 1; p < 4; p++) send_pixel(16'h0000, 1'b0);
    tick(); tick(); tick();
    check("ovf_level", 64'(fifo_level), 64'd8);
    check("ovf_flag",  64'(overflow),   64'd1);
`ifdef GRAYSCALE_PACK_OVF_COUNT_EN
    check("ovf_count", 64'(overflow_count), 64'd1);
`endif
    m_word_ready = 1'b1;
    for (int w = 0; w < 8; w++) expect_word($sformatf("ovf_drain%0d", w), {24'h0, ovf_gray[w]}, 1'b0);
    check("ovf_empty",  64'(m_word_valid), 64'd0);
    check("ovf_sticky", 64'(overflow),     64'd1);

    // Push and pop in the same cycle while full.
    do_reset();
    m_word_ready = 1'b0;
    for (int p = 0; p < 32; p++) send_pixel(16'hFFFF, 1'b0);
    tick(); tick(); tick();
    check("pp_full_level", 64'(fifo_level), 64'd8);
    for (int p = 0; p < 4; p++) send_pixel(16'h001F, 1'b0);
    tick();
    m_word_ready = 1'b1;   // pop coincides with the push on the next edge
    tick();
    m_word_ready = 1'b0;
    check("pp_level", 64'(fifo_level), 64'd8);
    check("pp_ovf",   64'(overflow),   64'd0);
    m_word_ready = 1'b1;
    for (int w = 0; w < 7; w++) expect_word($sformatf("pp_drain%0d", w), 32'hFFFFFFFF, 1'b0);
    expect_word("pp_new", 32'h12121212, 1'b0);

    // Reset mid-word discards the partial bytes.
    send_pixel(16'h001F, 1'b0);
    send_pixel(16'h001F, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int p = 0; p < 4; p++) send_pixel(16'hFFFF, 1'b0);
    expect_word("rmw_word", 32'hFFFFFFFF, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check("rmw_no_extra", 64'(m_word_valid), 64'd0);
    check("rmw_level",    64'(fifo_level),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/grayscale_pack_stream.md
# grayscale_pack_stream

Streaming RGB565-to-grayscale conversion and packing stage between the camera interface and the DMA/bus-master that writes frames to memory. Each incoming RGB565 pixel becomes one 8-bit luminance byte, using the same coefficient set as the grayscale custom instruction. Four bytes are packed into one 32-bit word and buffered in a small FIFO, drained over a valid/ready handshake. The camera side cannot be stalled, so words that find the FIFO full are dropped and flagged.

## Interface
- `FIFO_DEPTH_LOG2`, default 3, log2 of FIFO depth in 32-bit words (default 8 words).
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `s_pixel_valid` in 1: `s_pixel_data` holds a pixel this cycle. There is no ready signal; every valid pixel is consumed.
- `s_pixel_data` in 16: RGB565 pixel: R=[15:11], G=[10:5], B=[4:0].
- `s_end_of_line` in 1: qualified by `s_pixel_valid`; marks the last pixel of a line.
- `m_word_valid` out 1: FIFO head is valid.
- `m_word_data` out 32: packed gray bytes; first pixel in [7:0], fourth in [31:24].
- `m_word_last` out 1: the word holds the last pixel of a line.
- `m_word_ready` in 1: consumer accepts the word when it is high together with `m_word_valid`.
- `fifo_level` out `FIFO_DEPTH_LOG2`+1: number of words stored.
- `overflow` out 1: sticky; set when a word is dropped.

## Operation
- **Channel expansion to 8 bits:** R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- **Luminance:** gray=(54·R8+183·G8+19·B8)>>8.
  - Coefficients sum to 256, so the result is 0..255 and never saturates.
  - The accumulator is 16 bits wide.
- **Conversion pipeline, two register stages:**
  - S1 registers the three products, valid and EOL.
  - S2 registers the gray byte, valid and EOL.
- **Packer:** a 2-bit byte index, states BYTE0→BYTE1→BYTE2→BYTE3→BYTE0.
  - Each S2-valid byte is written to lane [index] of the pack register.
  - The word is pushed when index=3, or when the S2 byte carries EOL.
  - **Partial word on EOL:** unwritten upper lanes are zero; `last`=1; index returns to 0.
  - EOL on lane 3 yields a full word with `last`=1.
- **FIFO:** stores {last, data}, 33 bits.
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - A full FIFO with no pop drops the word, sets `overflow`, and still resets the pack index.
  - Simultaneous push and pop when full: both occur, `fifo_level` is unchanged, no overflow.
  - A pop from an empty FIFO is impossible, because `m_word_valid`=0.
- **Reset:** clears pipeline valids, pack index, pack register, FIFO pointers and `overflow`.
  - A partially packed word is discarded.
  - Reset values: `m_word_valid`=0, `m_word_last`=0, `m_word_data`=0, `fifo_level`=0, `overflow`=0.
- `overflow` is cleared only by reset.

## Timing
- **Latency:** when the 4th pixel is sampled in cycle N and the FIFO is empty, `m_word_valid`=1 with data in cycle N+3.
- **Throughput:** one pixel per cycle sustained, one word per cycle drain.
- FIFO outputs come straight from registered storage (head), with no combinational path from `m_word_ready` to `m_word_valid` or data.
- `m_word_data` and `m_word_last` are held stable while `m_word_valid`=1 and `m_word_ready`=0.
- `fifo_level` updates the cycle after a push or pop.

## Configuration
- **`GRAYSCALE_PACK_OVF_COUNT_EN` defined:** adds output `overflow_count`, 16 bits.
  - Saturating count of dropped words, holding at 0xFFFF.
  - Reset to 0.
- **Not defined:** the port and counter are absent; only the sticky `overflow` bit exists.

## Structure
- **Package `grayscale_pack_pkg`:**
  - Coefficient constants: COEF_R=54, COEF_G=183, COEF_B=19.
  - PIXEL_W=16, GRAY_W=8, WORD_W=32, BYTES_PER_WORD=4.
  - Packed FIFO entry type {last, data}.
- **Sub-module `grayscale_pack_fifo`:** synchronous FIFO, parameterised by depth, exposing push, pop, full, empty and level.
- The conversion pipeline and packer stay inline.

## Test plan
- **Reset:** assert `reset` for 2 cycles → `m_word_valid`=0, `fifo_level`=0, `overflow`=0, `m_word_data`=0.
- **Packing and latency:** pixels 0xFFFF, 0x0000, 0xF800, 0x07E0 on consecutive cycles, `m_word_ready`=1 → `m_word_data`=0xB63500FF, `last`=0, three cycles after the 4th pixel.
- **Partial word on EOL:** six pixels 0x001F, EOL on the 6th → 0x12121212 with `last`=0, then 0x00001212 with `last`=1.
- **Overflow:** `m_word_ready`=0, 36 pixels → `fifo_level`=8, 9th word dropped, `overflow`=1 (`overflow_count`=1 with the macro). Then drain 8 words intact, in order.
- **Push and pop when full:** FIFO full, `m_word_ready`=1 in the same cycle a new word pushes → `fifo_level` stays 8, `overflow` stays 0.
- **Reset mid-word:** `reset` after 2 pixels, then 4 pixels of 0xFFFF → exactly one word, 0xFFFFFFFF, with no stale bytes.
